serial_add: RTL and testbench

SERIAL_ADD -- requirements
Module: serial_add

---
 rtl/serial_add.sv | 138 +++++++++++++
 tb/tb_serial_add.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/serial_add.sv
// Bit-serial adder/subtractor: one shared full adder (two half adders + OR)
// walks the operands LSB first, one bit per clock, and publishes the result at the end.

module HalfAdder (
  input  logic x,
  input  logic y,
  output logic s,
  output logic c
);
  assign s = x ^ y;
  assign c = x & y;
endmodule

module serial_add #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] out,
  output logic             carry,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic               c_q, c_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [WIDTH-2:0]   res_q, res_d;
  logic [WIDTH-1:0]   out_q, out_d;
  logic               carry_q, carry_d;

  logic fa_x, fa_y;
  logic ha0_s, ha0_c;
  logic fa_sum, ha1_c;
  logic fa_cout;

  assign fa_x = a_q[cnt_q];
  assign fa_y = b_q[cnt_q];

  HalfAdder u_ha0 (
    .x (fa_x),
    .y (fa_y),
    .s (ha0_s),
    .c (ha0_c)
  );

  HalfAdder u_ha1 (
    .x (ha0_s),
    .y (c_q),
    .s (fa_sum),
    .c (ha1_c)
  );

  assign fa_cout = ha0_c | ha1_c;

  // Only WIDTH-1 bits are shifted in; the last sum bit goes straight into out.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    c_d     = c_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    out_d   = out_q;
    carry_d = carry_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b ^ {WIDTH{sub}};
          c_d     = sub;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        res_d = (WIDTH-1)'({fa_sum, res_q} >> 1);
        c_d   = fa_cout;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_BIT) begin
          out_d   = {fa_sum, res_q};
          carry_d = fa_cout;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= 1'b0;
      cnt_q   <= '0;
      res_q   <= '0;
      out_q   <= '0;
      carry_q <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      out_q   <= out_d;
      carry_q <= carry_d;
    end
  end

  assign out   = out_q;
  assign carry = carry_q;
  assign busy  = (state_q == RUN);
  assign done  = (state_q == DONE);

endmodule

// File: tb/tb_serial_add.sv
// Directed bench for serial_add: hand-computed vectors plus a held-start run
// checked against an arithmetic golden model.

module tb_serial_add;

  localparam int unsigned W = 16;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic         sub;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [W-1:0] out;
  logic         carry;
  logic         busy;
  logic         done;

  int checks;
  int errors;

  logic [W-1:0] exp_out;
  logic         exp_carry;

  logic [W:0]   held_exp [0:4];

  serial_add #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .sub   (sub),
    .a     (a),
    .b     (b),
    .out   (out),
    .carry (carry),
    .busy  (busy),
    .done  (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [W:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                       input logic s);
    return {1'b0, x} + {1'b0, y ^ {W{s}}} + (W+1)'(s);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Caller must be sitting just after a falling edge; the next rising edge accepts.
  // ign_k > 0 pulses a stray start (a=0x1234) at that RUN cycle.
  task automatic do_op(input logic [W-1:0] xa, input logic [W-1:0] xb, input logic xs,
                       input int ign_k, input string tag);
    logic [W:0] r;
    r     = model(xa, xb, xs);
    a     = xa;
    b     = xb;
    sub   = xs;
    start = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      start = 1'b0;
      a     = W'($urandom);
      b     = W'($urandom);
      sub   = 1'($urandom);
      if (k == ign_k) begin
        start = 1'b1;
        a     = 16'h1234;
      end
      check({tag, "_busy"}, 32'(busy), 32'd1);
      check({tag, "_nodone"}, 32'(done), 32'd0);
      if (k == 1 || k == 8 || k == 16) begin
        check({tag, "_hold_out"}, 32'(out), 32'(exp_out));
        check({tag, "_hold_carry"}, 32'(carry), 32'(exp_carry));
      end
    end
    @(negedge clk);
    start = 1'b0;
    exp_out   = r[W-1:0];
    exp_carry = r[W];
    check({tag, "_done"}, 32'(done), 32'd1);
    check({tag, "_idle_busy"}, 32'(busy), 32'd0);
    check({tag, "_out"}, 32'(out), 32'(exp_out));
    check({tag, "_carry"}, 32'(carry), 32'(exp_carry));
    @(negedge clk);
    check({tag, "_done_fall"}, 32'(done), 32'd0);
    check({tag, "_busy_after"}, 32'(busy), 32'd0);
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    exp_out   = '0;
    exp_carry = 1'b0;
    rst_n     = 1'b0;
    start     = 1'b0;
    sub       = 1'b0;
    a         = '0;
    b         = '0;

    // Reset state
    #1;
    check("rst_out", 32'(out), 32'd0);
    check("rst_carry", 32'(carry), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed arithmetic
    do_op(16'h0001, 16'h0001, 1'b0, 0, "add_1_1");
    check("add_1_1_val", 32'(out), 32'h0002);
    @(negedge clk);
    do_op(16'hFFFF, 16'h0001, 1'b0, 0, "add_ovf");
    check("add_ovf_val", {15'd0, carry, out}, {15'd0, 1'b1, 16'h0000});
    @(negedge clk);
    do_op(16'h0005, 16'h0003, 1'b1, 0, "sub_5_3");
    check("sub_5_3_val", {15'd0, carry, out}, {15'd0, 1'b1, 16'h0002});
    @(negedge clk);
    do_op(16'h0003, 16'h0005, 1'b1, 0, "sub_3_5");
    check("sub_3_5_val", {15'd0, carry, out}, {15'd0, 1'b0, 16'hFFFE});
    @(negedge clk);

    // Stray start mid-run is ignored and not queued
    do_op(16'h00FF, 16'h0001, 1'b0, 5, "ign");
    check("ign_val", 32'(out), 32'h0100);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("ign_no_second", 32'(busy), 32'd0);
      check("ign_out_stays", 32'(out), 32'h0100);
    end

    // Reset mid-operation
    a     = 16'h1111;
    b     = 16'h2222;
    sub   = 1'b0;
    start = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      start = 1'b0;
    end
    check("mid_busy_pre", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_busy", 32'(busy), 32'd0);
    check("mid_out", 32'(out), 32'd0);
    check("mid_carry", 32'(carry), 32'd0);
    check("mid_done", 32'(done), 32'd0);
    repeat (2) @(negedge clk);
    exp_out   = '0;
    exp_carry = 1'b0;
    rst_n     = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("mid_never_done", 32'(done), 32'd0);
      check("mid_out_zero", 32'(out), 32'd0);
    end

    // First edge after reset release accepts start
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    do_op(16'h1234, 16'h4321, 1'b0, 0, "post_rst");
    check("post_rst_val", 32'(out), 32'h5555);
    @(negedge clk);

    // Held start: one operation every W+2 cycles, operands change every cycle
    start = 1'b1;
    a     = W'($urandom);
    b     = W'($urandom);
    sub   = 1'($urandom);
    held_exp[0] = model(a, b, sub);
    for (int j = 1; j <= 89; j++) begin
      int m;
      @(negedge clk);
      m = j % (W + 2);
      check("held_busy", 32'(busy), 32'((m >= 1 && m <= 16) ? 1 : 0));
      check("held_done", 32'(done), 32'((m == 17) ? 1 : 0));
      if (m == 17) begin
        check("held_out", 32'(out), 32'(held_exp[j / (W + 2)][W-1:0]));
        check("held_carry", 32'(carry), 32'(held_exp[j / (W + 2)][W]));
      end
      a   = W'($urandom);
      b   = W'($urandom);
      sub = 1'($urandom);
      if (m == 0) held_exp[j / (W + 2)] = model(a, b, sub);
    end
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("held_stopped", 32'(busy), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
